// File: rtl/dest_tag_pipe_pkg.sv
// Shared types and constants for the destination-tag pipeline.
// Slot layout is {wr, rd}; an empty slot is all zeros.
package dest_tag_pipe_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 3;
    localparam int unsigned DEF_CNT_W      = 16;

    typedef struct packed {
        logic                      wr;
        logic [DEF_REG_ADDR_W-1:0] rd;
    } tag_slot_t;

    localparam tag_slot_t SLOT_EMPTY = '{wr: 1'b0, rd: '0};

endpackage

// File: rtl/dest_tag_pipe_if.sv
// ID-side inputs, pipeline controls and per-stage tag outputs of dest_tag_pipe.
// master drives ID/control signals; slave is the tag pipe itself.
interface dest_tag_pipe_if #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    logic [REG_ADDR_W-1:0] Write_register_ID;
    logic                  RegWrite_ID;
    logic                  stall;
    logic                  flush_ID;
    logic                  flush_EX;
    logic                  freeze;

    logic [REG_ADDR_W-1:0] Write_register_EX;
    logic                  RegWrite_EX;
    logic [REG_ADDR_W-1:0] Write_register_MEM;
    logic                  RegWrite_MEM;
    logic [REG_ADDR_W-1:0] Write_register_WB;
    logic                  RegWrite_WB;
    logic [NREGS-1:0]      busy;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output Write_register_ID, RegWrite_ID, stall, flush_ID, flush_EX, freeze,
        input  Write_register_EX, RegWrite_EX, Write_register_MEM, RegWrite_MEM,
        input  Write_register_WB, RegWrite_WB, busy, bubble_cnt
    );

    modport slave (
        input  Write_register_ID, RegWrite_ID, stall, flush_ID, flush_EX, freeze,
        output Write_register_EX, RegWrite_EX, Write_register_MEM, RegWrite_MEM,
        output Write_register_WB, RegWrite_WB, busy, bubble_cnt
    );

endinterface

// File: rtl/dest_tag_pipe_tag_slot.sv
// One {wr, rd} pipeline slot: async reset, hold enable, synchronous clear.
// Clear wins over hold so a frozen slot can still be squashed in place.
module dest_tag_pipe_tag_slot
    import dest_tag_pipe_pkg::*;
#(
    parameter type slot_t = tag_slot_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  clr,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= slot_t'('0);
        end else if (clr) begin
            q <= slot_t'('0);
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dest_tag_pipe.sv
// Carries destination-register tags through EX/MEM/WB for hazard detection,
// with a per-register busy mask and a saturating bubble counter.
module dest_tag_pipe
    import dest_tag_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input logic          clk,
    input logic          rst,
    dest_tag_pipe_if.slave bus
);

    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic                  wr;
        logic [REG_ADDR_W-1:0] rd;
    } slot_t;

    localparam slot_t Empty = '{wr: 1'b0, rd: '0};

    slot_t ex_d, mem_d;
    slot_t ex_q, mem_q, wb_q;
    logic  bubble;
    logic  ex_clr, mem_clr;

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    // stall and flush_ID together still make a single bubble
    assign bubble = bus.stall | bus.flush_ID;

    always_comb begin
        ex_d  = Empty;
        mem_d = ex_q;
        if (!bubble) begin
            ex_d.wr = bus.RegWrite_ID;
            ex_d.rd = bus.Write_register_ID;
        end
    end

    // Frozen EX can only be squashed in place; unfrozen, flush_EX empties what moves to MEM.
    assign ex_clr  = bus.freeze & bus.flush_EX;
    assign mem_clr = ~bus.freeze & bus.flush_EX;

    dest_tag_pipe_tag_slot #(
        .slot_t (slot_t)
    ) u_slot_ex (
        .clk  (clk),
        .rst  (rst),
        .hold (bus.freeze),
        .clr  (ex_clr),
        .d    (ex_d),
        .q    (ex_q)
    );

    dest_tag_pipe_tag_slot #(
        .slot_t (slot_t)
    ) u_slot_mem (
        .clk  (clk),
        .rst  (rst),
        .hold (bus.freeze),
        .clr  (mem_clr),
        .d    (mem_d),
        .q    (mem_q)
    );

    dest_tag_pipe_tag_slot #(
        .slot_t (slot_t)
    ) u_slot_wb (
        .clk  (clk),
        .rst  (rst),
        .hold (bus.freeze),
        .clr  (1'b0),
        .d    (mem_q),
        .q    (wb_q)
    );

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!bus.freeze && bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    always_comb begin
        bus.busy = '0;
        if (ex_q.wr) begin
            bus.busy[ex_q.rd] = 1'b1;
        end
        if (mem_q.wr) begin
            bus.busy[mem_q.rd] = 1'b1;
        end
        if (wb_q.wr) begin
            bus.busy[wb_q.rd] = 1'b1;
        end
    end

    assign bus.Write_register_EX  = ex_q.rd;
    assign bus.RegWrite_EX        = ex_q.wr;
    assign bus.Write_register_MEM = mem_q.rd;
    assign bus.RegWrite_MEM       = mem_q.wr;
    assign bus.Write_register_WB  = wb_q.rd;
    assign bus.RegWrite_WB        = wb_q.wr;
    assign bus.bubble_cnt         = bubble_cnt_q;

    // Width of busy must match the decoded register space.
    logic [NREGS-1:0] unused_busy_width;
    assign unused_busy_width = bus.busy;

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Directed, table-driven bench for dest_tag_pipe with a 4-bit bubble counter.
module tb_dest_tag_pipe;

    localparam int unsigned RW = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned NV = 19;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dest_tag_pipe_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    dest_tag_pipe #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ex/mem/wb expectations are packed {wr, reg}
    typedef struct {
        logic       rw;
        logic [2:0] wreg;
        logic       st;
        logic       fi;
        logic       fe;
        logic       fz;
        logic [3:0] ex;
        logic [3:0] mem;
        logic [3:0] wb;
        logic [7:0] busy;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic rw, input logic [2:0] wreg, input logic st,
                                input logic fi, input logic fe, input logic fz,
                                input logic [3:0] ex, input logic [3:0] mem,
                                input logic [3:0] wb, input logic [7:0] busy,
                                input logic [3:0] cnt);
        vec_t v;
        v.rw = rw; v.wreg = wreg; v.st = st; v.fi = fi; v.fe = fe; v.fz = fz;
        v.ex = ex; v.mem = mem; v.wb = wb; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [2:0] wreg, input logic st,
                         input logic fi, input logic fe, input logic fz);
        bus.RegWrite_ID       = rw;
        bus.Write_register_ID = wreg;
        bus.stall             = st;
        bus.flush_ID          = fi;
        bus.flush_EX          = fe;
        bus.freeze            = fz;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ex, input logic [3:0] mem,
                             input logic [3:0] wb, input logic [7:0] busy,
                             input logic [3:0] cnt);
        check({tag, " ex"},   {bus.RegWrite_EX, bus.Write_register_EX}, ex);
        check({tag, " mem"},  {bus.RegWrite_MEM, bus.Write_register_MEM}, mem);
        check({tag, " wb"},   {bus.RegWrite_WB, bus.Write_register_WB}, wb);
        check({tag, " busy"}, bus.busy, busy);
        check({tag, " cnt"},  bus.bubble_cnt, cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //             rw wreg st fi fe fz   ex     mem    wb     busy    cnt
        vecs[0]  = mk(1, 3'd3, 0, 0, 0, 0, 4'hB, 4'h0, 4'h0, 8'h08, 4'd0);
        vecs[1]  = mk(1, 3'd5, 0, 0, 0, 0, 4'hD, 4'hB, 4'h0, 8'h28, 4'd0);
        vecs[2]  = mk(1, 3'd6, 0, 0, 0, 0, 4'hE, 4'hD, 4'hB, 8'h68, 4'd0);
        vecs[3]  = mk(1, 3'd2, 1, 0, 0, 0, 4'h0, 4'hE, 4'hD, 8'h60, 4'd1);
        vecs[4]  = mk(1, 3'd2, 1, 0, 0, 0, 4'h0, 4'h0, 4'hE, 8'h40, 4'd2);
        vecs[5]  = mk(1, 3'd2, 0, 0, 0, 0, 4'hA, 4'h0, 4'h0, 8'h04, 4'd2);
        vecs[6]  = mk(1, 3'd1, 0, 0, 0, 0, 4'h9, 4'hA, 4'h0, 8'h06, 4'd2);
        vecs[7]  = mk(1, 3'd2, 0, 0, 0, 0, 4'hA, 4'h9, 4'hA, 8'h06, 4'd2);
        vecs[8]  = mk(1, 3'd4, 0, 0, 0, 0, 4'hC, 4'hA, 4'h9, 8'h16, 4'd2);
        vecs[9]  = mk(1, 3'd7, 1, 1, 0, 1, 4'hC, 4'hA, 4'h9, 8'h16, 4'd2);
        vecs[10] = mk(1, 3'd7, 1, 1, 0, 1, 4'hC, 4'hA, 4'h9, 8'h16, 4'd2);
        vecs[11] = mk(1, 3'd7, 1, 1, 0, 1, 4'hC, 4'hA, 4'h9, 8'h16, 4'd2);
        vecs[12] = mk(1, 3'd7, 1, 0, 1, 1, 4'h0, 4'hA, 4'h9, 8'h06, 4'd2);
        vecs[13] = mk(1, 3'd7, 0, 0, 0, 0, 4'hF, 4'h0, 4'hA, 8'h84, 4'd2);
        vecs[14] = mk(1, 3'd0, 0, 0, 1, 0, 4'h8, 4'h0, 4'h0, 8'h01, 4'd2);
        vecs[15] = mk(1, 3'd3, 1, 1, 0, 0, 4'h0, 4'h8, 4'h0, 8'h01, 4'd3);
        vecs[16] = mk(0, 3'd5, 0, 0, 0, 0, 4'h5, 4'h0, 4'h8, 8'h01, 4'd3);
        vecs[17] = mk(1, 3'd0, 0, 0, 0, 0, 4'h8, 4'h5, 4'h0, 8'h01, 4'd3);
        vecs[18] = mk(1, 3'd0, 0, 0, 0, 0, 4'h8, 4'h8, 4'h5, 8'h01, 4'd3);

        drive(0, 3'd0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        check_all("reset", 4'h0, 4'h0, 4'h0, 8'h00, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rw, vecs[i].wreg, vecs[i].st, vecs[i].fi, vecs[i].fe, vecs[i].fz);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].mem, vecs[i].wb,
                      vecs[i].busy, vecs[i].cnt);
        end

        // Asynchronous reset between edges with the pipe full.
        drive(1, 3'd6, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'h0, 4'h0, 4'h0, 8'h00, 4'd0);
        tick();
        check_all("rst_held", 4'h0, 4'h0, 4'h0, 8'h00, 4'd0);
        rst = 1'b0;

        // Saturation of the 4-bit bubble counter.
        drive(1, 3'd1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("sat%0d cnt", i), bus.bubble_cnt, (i + 1 > 15) ? 15 : i + 1);
        end
        drive(1, 3'd1, 1, 1, 0, 0);
        tick();
        check("sat_hold cnt", bus.bubble_cnt, 4'd15);
        drive(1, 3'd1, 0, 0, 0, 0);
        tick();
        check("sat_idle cnt", bus.bubble_cnt, 4'd15);
        check("sat_idle ex", {bus.RegWrite_EX, bus.Write_register_EX}, 4'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dest_tag_pipe.md
Name: dest_tag_pipe

Overview:
- Writer side of the RAW-hazard interface. It carries each instruction's destination tag down the EX, MEM and WB stages.
- It sources the Write_register_EX/MEM and RegWrite_EX/MEM signals that the hazard detection unit compares against Rs/Rt in ID.
- It also provides a per-register busy mask and a bubble-cycle performance counter.
- It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and obeys the same stall, flush and freeze controls.

Parameters:
REG_ADDR_W, 3, register-specifier width; number of architectural registers is NREGS = 2**REG_ADDR_W.
CNT_W, 16, width of the bubble counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
Write_register_ID  input  REG_ADDR_W  destination register of the instruction in ID
RegWrite_ID  input  1  instruction in ID writes the register file
stall  input  1  hazard stall; insert a bubble into EX this cycle
flush_ID  input  1  squash the instruction in ID (taken branch/jump); insert a bubble into EX
flush_EX  input  1  squash the instruction currently in EX
freeze  input  1  memory-stall freeze; whole pipe holds
Write_register_EX  output  REG_ADDR_W  EX-stage destination tag
RegWrite_EX  output  1  EX-stage write-valid
Write_register_MEM  output  REG_ADDR_W  MEM-stage destination tag
RegWrite_MEM  output  1  MEM-stage write-valid
Write_register_WB  output  REG_ADDR_W  WB-stage destination tag
RegWrite_WB  output  1  WB-stage write-valid
busy  output  NREGS  bit r = 1 when any valid in-flight write in EX/MEM/WB targets register r
bubble_cnt  output  CNT_W  count of bubble cycles inserted into EX, saturating

Behaviour:
- State: three slots (EX, MEM, WB). Each slot holds {wr, reg}. All outputs are driven directly from the slot flops; busy is a combinational OR-decode of those slots.
- Reset: asserting rst clears every slot and bubble_cnt to 0 immediately. All outputs read 0. Reset mid-operation discards all in-flight tags.
- Normal advance (freeze=0), at each rising clk:
  - WB <= MEM.
  - MEM <= flush_EX ? {0, 0} : EX.
  - EX <= (stall | flush_ID) ? {0, 0} : {RegWrite_ID, Write_register_ID}.
- Latency: a tag presented in ID at cycle N appears on the EX outputs at N+1, the MEM outputs at N+2, and the WB outputs at N+3. It leaves the pipe after N+3.
- Freeze=1:
  - MEM and WB hold.
  - EX holds, except that flush_EX=1 clears EX in place.
  - stall and flush_ID are ignored, and bubble_cnt does not count.
- Priority: rst > freeze > flush_EX / flush_ID > stall. When stall and flush_ID are asserted together, exactly one bubble is inserted and counted once.
- A squashed slot is always stored as {0, 0}. The reg field is zeroed, not left stale.
- bubble_cnt:
  - Increments by 1 on each non-freeze cycle where stall | flush_ID = 1.
  - Saturates at 2**CNT_W-1 and never wraps.
  - Reset is the only way to clear it.
- busy:
  - Bits for slots with wr=0 never contribute.
  - Duplicate targets across slots OR together.
  - Register 0 is treated like any other register; there is no hardwired zero.
- Rs/Rt comparison and forwarding are not done here. This block only produces tags.

Decomposition:
- Shared package:
  - the REG_ADDR_W default
  - the slot struct/typedef {wr, reg}
  - the bubble constant SLOT_EMPTY = {0, 0}
- Natural sub-module: tag_slot. It is one {wr, reg} flop stage with async reset, a hold enable and a synchronous clear, instantiated three times.
- The busy decode and the saturating counter remain in the top level.

Test Plan:
- Reset/flow:
  - Stimulus: release rst; drive RegWrite_ID=1 with Write_register_ID=3, then 5, then 6 on three consecutive cycles.
  - Response: EX/MEM/WB tags read 6/5/3 after the third edge; busy=8'b0110_1000; bubble_cnt=0.
- Stall bubble:
  - Stimulus: drive reg 2 with stall=1 for 2 cycles, then stall=0.
  - Response: EX reads {0, 0} for 2 cycles, then {1, 2}; bubble_cnt=2.
- Freeze hold:
  - Stimulus: fill the pipe with tags 1, 2, 4; assert freeze for 3 cycles with stall=1 and flush_ID=1.
  - Response: all slots unchanged; bubble_cnt unchanged.
  - Stimulus: also assert flush_EX=1 during freeze.
  - Response: EX is cleared and MEM/WB hold.
- Squash paths:
  - Stimulus: flush_EX=1 with EX={1, 7}.
  - Response: MEM reads {0, 0} next cycle and busy[7] drops.
  - Stimulus: flush_ID and stall asserted together.
  - Response: bubble_cnt increments by 1.
- Saturation:
  - Stimulus: CNT_W=4; hold stall=1 for 20 cycles.
  - Response: bubble_cnt reaches 15 and stays at 15.
- Async reset:
  - Stimulus: assert rst between clock edges with the pipe full.
  - Response: all outputs go to 0 before the next edge.
